rpn_stack_ctrl: RTL
===================

Name: rpn_stack_ctrl

Overview:
Reverse-Polish evaluation sequencer that sits directly upstream of the 32x32 LIFO stack and also consumes its pop data.
- Accepts a token stream: operands and operators.
- Operands are pushed onto the LIFO.
- Operators pop two operands, compute a result and push the result back.
- Drives the LIFO's w_en/r_en/data_in, and reads its data_out/full/empty.

Parameters:
- WIDTH, 32, data width; must equal the LIFO data width.
- OPC_W, 3, opcode field width, taken from tok_data[OPC_W-1:0].

Ports:
- clk  in  1  clock, shared with the LIFO.
- rst  in  1  asynchronous, active-high reset.
- tok_valid  in  1  token present.
- tok_ready  out  1  token accepted when tok_valid && tok_ready.
- tok_is_op  in  1  1 = operator, 0 = operand.
- tok_data  in  WIDTH  operand value, or opcode in bits [OPC_W-1:0].
- stk_w_en  out  1  to LIFO w_en.
- stk_r_en  out  1  to LIFO r_en.
- stk_data_in  out  WIDTH  to LIFO data_in.
- stk_data_out  in  WIDTH  from LIFO data_out; registered, valid the cycle after r_en.
- stk_full  in  1  from LIFO full.
- stk_empty  in  1  from LIFO empty.
- res_valid  out  1  one-cycle pulse when an operator result is pushed.
- res_data  out  WIDTH  operator result.
- err_code  out  2  00 none, 01 overflow, 10 underflow, 11 illegal opcode; sticky.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; opA, opB, res_data = 0; err_code = 00.
  - tok_ready, stk_w_en, stk_r_en, res_valid = 0 while rst is high.
- Moore FSM. All stack controls are decoded from the state register only, so they are glitch-free and never asserted together.
- States: IDLE, PUSH_D, POP_B, LATCH_B, POP_A, LATCH_A, PUSH_R, ERR.
- tok_ready = 1 only in IDLE (and rst low).
- Operand accepted in IDLE at cycle T:
  - If stk_full at T: go to ERR, err_code = 01, no push.
  - Otherwise: PUSH_D at T+1 with stk_w_en = 1 and stk_data_in = the latched operand; IDLE at T+2.
  - Throughput is 1 operand per 2 cycles, so the LIFO flags have settled before the next check.
- Operator accepted in IDLE at cycle T, precedence as follows:
  - Illegal opcode: go to ERR with err_code = 11.
  - Else if stk_empty at T: go to ERR with err_code = 10.
  - Else:
    - T+1 POP_B: stk_r_en = 1.
    - T+2 LATCH_B: opB <= stk_data_out; if stk_empty (only one operand existed), go to ERR with err_code = 10.
    - T+3 POP_A: stk_r_en = 1.
    - T+4 LATCH_A: res_data <= f(stk_data_out as A, opB).
    - T+5 PUSH_R: stk_w_en = 1, stk_data_in = res_data, res_valid = 1.
    - T+6 IDLE.
  - Operator latency is 6 cycles from accept to the next tok_ready.
- Opcodes:
  - 0 ADD: A+B.
  - 1 SUB: A-B, where A is the deeper operand.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 MUL (see Optional Feature).
  - 6 and 7: illegal.
- Arithmetic is modulo 2^WIDTH; carries and borrows are discarded.
- PUSH_R can never overflow, because two entries were freed.
- ERR is terminal: tok_ready = 0, no stack activity, err_code held until rst.
- On an underflow detected at LATCH_B, the popped operand is lost; the stack is left empty.
- Reset mid-operator aborts immediately; outputs return to reset values asynchronously.
- The LIFO's synchronous rst is tied to the same rst net, so stack contents clear on the next clk edge.
- tok_data and tok_is_op are sampled only on handshake; other values are don't-care.

Optional Feature:
- Macro: RPN_MUL_EN.
- Defined: opcode 5 = MUL, result is the low WIDTH bits of A*B, same 6-cycle latency (product registered in LATCH_A).
- Undefined: opcode 5 is illegal (err_code = 11) and no multiplier is instantiated.

Decomposition:
- Package rpn_pkg holds:
  - Opcode localparams (OP_ADD..OP_MUL).
  - FSM state encoding.
  - err_code values ERR_NONE/ERR_OVF/ERR_UDF/ERR_ILL.
- Sub-module rpn_alu: purely combinational (a, b, opc) -> (y, illegal).
  - The MUL branch sits under RPN_MUL_EN.
  - The FSM uses its illegal output for the decode check in IDLE.

Test Plan:
- Operand 3, operand 4, operator ADD:
  - Two PUSH_D cycles.
  - stk_r_en high at T+1 and T+3.
  - At T+5: res_valid = 1, res_data = 7, stk_w_en = 1, stk_data_in = 7.
  - LIFO depth ends at 1.
- Operand 10, operand 3, SUB -> res_data = 7. Operand 3, operand 10, SUB -> res_data = 0xFFFFFFF9.
- Single operand 5 then ADD -> err_code = 10 at T+3, tok_ready stays 0, stack empty. Operator on an empty stack -> err_code = 10 at T+1 with no r_en pulse.
- 32 operands then a 33rd -> err_code = 01, no stk_w_en for the 33rd, stack top still the 32nd value.
- Opcode 6 -> err_code = 11. Opcode 5:
  - With RPN_MUL_EN: 0x10000 * 0x10003 -> 0x00030000.
  - Without RPN_MUL_EN: err_code = 11.
- Assert rst during LATCH_A of an ADD -> outputs zero immediately, no PUSH_R, tok_ready = 1 after release, next ADD sequence is correct.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN stack sequencer: opcodes, FSM states, error codes.
package rpn_pkg;

   localparam int OP_ADD = 0;
   localparam int OP_SUB = 1;
   localparam int OP_AND = 2;
   localparam int OP_OR  = 3;
   localparam int OP_XOR = 4;
   localparam int OP_MUL = 5;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PUSH_D  = 3'd1,
      POP_B   = 3'd2,
      LATCH_B = 3'd3,
      POP_A   = 3'd4,
      LATCH_A = 3'd5,
      PUSH_R  = 3'd6,
      ERR     = 3'd7
   } state_t;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_OVF  = 2'b01;
   localparam logic [1:0] ERR_UDF  = 2'b10;
   localparam logic [1:0] ERR_ILL  = 2'b11;

endpackage

// File: rtl/rpn_alu.sv
// Combinational RPN operator unit. Opcode 5 (MUL) exists only when RPN_MUL_EN is defined.
module rpn_alu
   import rpn_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int OPC_W = 3
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OPC_W-1:0] opc,
   output logic [WIDTH-1:0] y,
   output logic             illegal
);

   always_comb begin
      y       = '0;
      illegal = 1'b0;
      case (opc)
         OPC_W'(OP_ADD): y = a + b;
         OPC_W'(OP_SUB): y = a - b;
         OPC_W'(OP_AND): y = a & b;
         OPC_W'(OP_OR):  y = a | b;
         OPC_W'(OP_XOR): y = a ^ b;
`ifdef RPN_MUL_EN
         OPC_W'(OP_MUL): y = a * b;
`endif
         default:        illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/rpn_stack_ctrl.sv
// Reverse-Polish sequencer driving a 32-deep LIFO; Moore FSM, stack controls decoded from state only.
// Optional MUL operator enabled by defining RPN_MUL_EN.
module rpn_stack_ctrl
   import rpn_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int OPC_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tok_valid,
   output logic             tok_ready,
   input  logic             tok_is_op,
   input  logic [WIDTH-1:0] tok_data,
   output logic             stk_w_en,
   output logic             stk_r_en,
   output logic [WIDTH-1:0] stk_data_in,
   input  logic [WIDTH-1:0] stk_data_out,
   input  logic             stk_full,
   input  logic             stk_empty,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_data,
   output logic [1:0]       err_code,
   output logic [2:0]       dbg_state
);

   state_t           state, state_nxt;
   logic [1:0]       err_nxt;
   logic [OPC_W-1:0] opc_q, alu_opc;
   logic [WIDTH-1:0] opnd_q, op_b, alu_y;
   logic             alu_illegal;
   logic             accept;

   // Token handshake: a token transfers on a clk edge where tok_valid && tok_ready;
   // tok_valid may be held without the token being consumed, and tok_ready never depends on tok_valid.
   assign accept = (state == IDLE) && tok_valid;

   // In IDLE the ALU decodes the incoming opcode for the legality check.
   assign alu_opc = (state == IDLE) ? tok_data[OPC_W-1:0] : opc_q;

   rpn_alu #(.WIDTH(WIDTH), .OPC_W(OPC_W)) u_alu (
      .a       (stk_data_out),
      .b       (op_b),
      .opc     (alu_opc),
      .y       (alu_y),
      .illegal (alu_illegal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         err_code <= ERR_NONE;
      end else begin
         state    <= state_nxt;
         err_code <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      err_nxt   = err_code;
      case (state)
         IDLE: begin
            if (accept) begin
               if (!tok_is_op) begin
                  if (stk_full) begin
                     state_nxt = ERR;
                     err_nxt   = ERR_OVF;
                  end else begin
                     state_nxt = PUSH_D;
                  end
               end else if (alu_illegal) begin
                  state_nxt = ERR;
                  err_nxt   = ERR_ILL;
               end else if (stk_empty) begin
                  state_nxt = ERR;
                  err_nxt   = ERR_UDF;
               end else begin
                  state_nxt = POP_B;
               end
            end
         end
         PUSH_D:  state_nxt = IDLE;
         POP_B:   state_nxt = LATCH_B;
         LATCH_B: begin
            // Empty after the first pop means only one operand existed.
            if (stk_empty) begin
               state_nxt = ERR;
               err_nxt   = ERR_UDF;
            end else begin
               state_nxt = POP_A;
            end
         end
         POP_A:   state_nxt = LATCH_A;
         LATCH_A: state_nxt = PUSH_R;
         PUSH_R:  state_nxt = IDLE;
         ERR:     state_nxt = ERR;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opnd_q   <= '0;
         opc_q    <= '0;
         op_b     <= '0;
         res_data <= '0;
      end else begin
         if (accept && !tok_is_op) opnd_q <= tok_data;
         if (accept && tok_is_op)  opc_q  <= tok_data[OPC_W-1:0];
         if (state == LATCH_B)     op_b   <= stk_data_out;
         if (state == LATCH_A)     res_data <= alu_y;
      end
   end

   assign tok_ready   = (state == IDLE) && !rst;
   assign stk_w_en    = (state == PUSH_D) || (state == PUSH_R);
   assign stk_r_en    = (state == POP_B) || (state == POP_A);
   assign stk_data_in = (state == PUSH_R) ? res_data : opnd_q;
   assign res_valid   = (state == PUSH_R);
   assign dbg_state   = state;

endmodule
